// File: rtl/fcb_pkg.sv
// fcb_pkg: shared constants and helpers for the credit-based flow-control block family.
package fcb_pkg;
    localparam int FCB_DEFAULT_CREDITS = 2;

    function automatic int fcb_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/fcb_credit_counter.sv
// fcb_credit_counter: saturating credit counter, decremented per send and incremented per returned credit.
module fcb_credit_counter
    import fcb_pkg::*;
#(
    parameter int max   = FCB_DEFAULT_CREDITS,
    parameter int cnt_w = fcb_cnt_width(max)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec,
    input  logic             inc,
    output logic [cnt_w-1:0] cnt,
    output logic             nonzero
);
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic [cnt_w:0]   sum;

    // One extra bit so a spurious return at max is seen and clamped, not wrapped.
    always_comb begin
        sum   = {1'b0, cnt_q} + (cnt_w+1)'(inc) - (cnt_w+1)'(dec);
        cnt_d = (sum > (cnt_w+1)'(max)) ? cnt_w'(max) : sum[cnt_w-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= cnt_w'(max);
        else     cnt_q <= cnt_d;
    end

    assign cnt     = cnt_q;
    assign nonzero = cnt_q != '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(inc && !dec && cnt_q == cnt_w'(max)));
            assert (!(dec && !inc && cnt_q == '0));
        end
    end
endmodule

// File: rtl/fcb_credit_tx.sv
// fcb_credit_tx: credit-gated transmitter forwarding each accepted word as a registered one-cycle pulse.
// Optional FCB_CREDIT_TX_BYPASS_EN lets a credit returned this cycle be spent immediately.
module fcb_credit_tx
    import fcb_pkg::*;
#(
    parameter int  w       = 0,
    parameter int  credits = FCB_DEFAULT_CREDITS,
    parameter int  cnt_w   = fcb_cnt_width(credits),
    localparam int dw      = (w < 1) ? 1 : w
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_vld,
    output logic          up_rdy,
    input  logic [dw-1:0] up_data,
    output logic          down_vld,
    output logic [dw-1:0] down_data,
    input  logic          credit_ret
);
    logic             fire, nonzero, down_vld_q;
    logic [dw-1:0]    down_data_q;
    logic [cnt_w-1:0] cnt;

    assign fire = up_vld & up_rdy;
`ifdef FCB_CREDIT_TX_BYPASS_EN
    assign up_rdy = nonzero | credit_ret;
`else
    assign up_rdy = nonzero;
`endif

    fcb_credit_counter #(.max(credits), .cnt_w(cnt_w)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .dec    (fire),
        .inc    (credit_ret),
        .cnt    (cnt),
        .nonzero(nonzero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) down_vld_q <= 1'b0;
        else     down_vld_q <= fire;
    end

    always_ff @(posedge clk) begin
        if (fire) down_data_q <= up_data;
    end

    assign down_vld  = down_vld_q;
    assign down_data = down_data_q;

    always_ff @(posedge clk) begin
        if (!rst) assert (cnt <= cnt_w'(credits));
    end
endmodule
